// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI4-Stream packet FIFO.
// A DEPTH-1 entry circular RAM feeds one output register (FWFT). The output
// register is filled eagerly whenever the RAM has data; tvalid is only raised
// once the held beat belongs to a committed packet or a forced cut-through.
module axis_pkt_fifo #(
  parameter int DATA_BITS = 64,
  parameter int DEPTH     = 64
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DATA_BITS-1:0]       s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]     s_axis_tkeep,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_BITS-1:0]       m_axis_tdata,
  output logic [DATA_BITS/8-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     occ,
  output logic [$clog2(DEPTH):0]     pkt_cnt,
  output logic                       cut_thru
);
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_N     = DEPTH - 1;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
  } beat_t;

  beat_t          mem_q [RAM_N];
  beat_t          out_q, out_d, s_beat;
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  occ_q, occ_d, pkt_q, pkt_d, ram_cnt, pc_after;
  logic           out_full_q, out_full_d, out_vld_q, out_vld_d;
  logic           cut_q, cut_d, up_q;
  logic           wr, rd, load, pkt_rd;

  // pointers wrap over the DEPTH-1 RAM entries, not a power of two
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RAM_N - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_beat   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign wr       = s_axis_tvalid & s_axis_tready;
  assign rd       = out_vld_q & m_axis_tready;
  assign ram_cnt  = occ_q - CW'(out_full_q);
  // output register refills from RAM whenever it frees up, valid or not
  assign load     = (ram_cnt != '0) & (~out_full_q | rd);
  assign pkt_rd   = rd & out_q.last;
  assign pc_after = pkt_q - CW'(pkt_rd);

  // next-state: pointers, counters, cut-through flag and output register
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    out_d  = out_q;
    if (wr) wptr_d = nxt(wptr_q);
    if (load) begin
      rptr_d = nxt(rptr_q);
      out_d  = mem_q[rptr_q];
    end
    occ_d = occ_q + CW'(wr) - CW'(rd);
    // a commit at this edge is excluded from release: first beat shows one edge later
    pkt_d = pc_after + CW'(wr & s_axis_tlast);
    cut_d = cut_q;
    if (cut_q && pkt_rd && (pc_after == '0))
      cut_d = 1'b0;
    else if ((occ_q == CW'(DEPTH)) && (pkt_q == '0))
      cut_d = 1'b1;
    out_full_d = load | (out_full_q & ~rd);
    // release uses the count after this edge's last-read, so a following
    // uncommitted packet is parked rather than exposed
    out_vld_d  = out_full_d & (cut_d | (pc_after != '0));
  end

  // state registers, cleared asynchronously
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      pkt_q      <= '0;
      cut_q      <= 1'b0;
      out_full_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      up_q       <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      pkt_q      <= pkt_d;
      cut_q      <= cut_d;
      out_full_q <= out_full_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      up_q       <= 1'b1;
    end
  end

  // beat storage; contents need no reset since pointers/occupancy gate use
  always_ff @(posedge aclk) begin
    if (wr) mem_q[wptr_q] <= s_beat;
  end

  assign s_axis_tready = up_q & (occ_q < CW'(DEPTH));
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign occ           = occ_q;
  assign pkt_cnt       = pkt_q;
  assign cut_thru      = cut_q;

endmodule
